control_sequencer: RTL and testbench

Hardwired control unit that drives the strobes of the `no_control_full` datapath: HLT, INC, REPC, REIR, REDMEM, RER, cu_A and cu_B. It sits directly upstream of the datapath. It runs a fetch / PC-increment / execute cycle, decodes the opcode read back from the instruction register, and produces one strobe set per clock. A halt state, an illegal-opcode flag and a retired-instruction counter support bring-up and verification.

---
 rtl/control_sequencer.sv | 108 ++++++++++
 tb/tb_control_sequencer.sv | 100 ++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/increment/execute control unit for the no_control_full datapath.
// Ports:
//   clk        - single rising-edge clock
//   reset_full - asynchronous active-low reset
//   ir_op      - opcode field of the datapath IR, sampled on the edge leaving INCPC
//   HLT, INC, REPC, REIR, REDMEM, RER - datapath strobes
//   cu_A, cu_B - A/B register selects (00 hold, 01 load result, 10 clear, 11 load bus)
//   state      - current FSM state (debug)
//   retired    - retired instruction count, wraps at 255
//   illegal    - high during EXEC1 of an undefined opcode
module control_sequencer #(
    parameter int IDLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_full,
    input  logic [3:0] ir_op,
    output logic       HLT,
    output logic       INC,
    output logic       REPC,
    output logic       REIR,
    output logic       REDMEM,
    output logic       RER,
    output logic [1:0] cu_A,
    output logic [1:0] cu_B,
    output logic [2:0] state,
    output logic [7:0] retired,
    output logic       illegal
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_INCPC = 3'd2,
        S_EXEC1 = 3'd3,
        S_EXEC2 = 3'd4,
        S_HALT  = 3'd7
    } state_t;

    localparam logic [3:0] LAST = 4'(IDLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] op_q, op_d;
    logic [7:0] retired_q, retired_d;
    logic       e1, e2;

    always_ff @(posedge clk or negedge reset_full) begin
        if (!reset_full) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    // Unused encodings fall through to the IDLE default
    always_comb begin
        state_d   = S_IDLE;
        cnt_d     = cnt_q;
        op_d      = op_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                state_d = (cnt_q >= LAST) ? S_FETCH : S_IDLE;
                cnt_d   = (cnt_q >= LAST) ? 4'd0 : cnt_q + 4'd1;
            end
            S_FETCH: state_d = S_INCPC;
            S_INCPC: begin
                op_d    = ir_op;
                state_d = (ir_op == 4'hF) ? S_HALT : S_EXEC1;
            end
            S_EXEC1: begin
                state_d   = (op_q == 4'h5) ? S_EXEC2 : S_FETCH;
                retired_d = (op_q == 4'h5) ? retired_q : retired_q + 8'd1;
            end
            S_EXEC2: begin
                state_d   = S_FETCH;
                retired_d = retired_q + 8'd1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode only registered state and latched op, never ir_op
    always_comb begin
        e1      = state_q == S_EXEC1;
        e2      = state_q == S_EXEC2;
        HLT     = state_q == S_HALT;
        INC     = state_q == S_INCPC;
        REPC    = state_q == S_INCPC;
        REIR    = state_q == S_FETCH;
        REDMEM  = e1 && op_q == 4'h4;
        RER     = e1 && (op_q == 4'h3 || op_q == 4'h5);
        cu_A    = (e1 && op_q == 4'h1) ? 2'b11 :
                  (e1 && op_q == 4'h6) ? 2'b10 :
                  e2                   ? 2'b01 : 2'b00;
        cu_B    = (e1 && op_q == 4'h2) ? 2'b11 :
                  (e1 && op_q == 4'h6) ? 2'b10 : 2'b00;
        illegal = e1 && op_q >= 4'h7 && op_q <= 4'hE;
        state   = state_q;
        retired = retired_q;
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer.
module tb_control_sequencer;
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, INCPC = 3'd2, EXEC1 = 3'd3, EXEC2 = 3'd4, HALT = 3'd7;

    logic       clk = 1'b0;
    logic       reset_full = 1'b0;
    logic [3:0] ir_op = 4'h0;
    logic       HLT, INC, REPC, REIR, REDMEM, RER, illegal;
    logic [1:0] cu_A, cu_B;
    logic [2:0] state;
    logic [7:0] retired;
    logic [9:0] vec;
    logic [7:0] ret = 8'd0;
    int         checks = 0;
    int         failures = 0;

    control_sequencer #(.IDLE_CYCLES(1)) dut (
        .clk(clk), .reset_full(reset_full), .ir_op(ir_op),
        .HLT(HLT), .INC(INC), .REPC(REPC), .REIR(REIR), .REDMEM(REDMEM), .RER(RER),
        .cu_A(cu_A), .cu_B(cu_B), .state(state), .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {HLT,INC,REPC,REIR,REDMEM,RER,cu_A,cu_B}
    assign vec = {HLT, INC, REPC, REIR, REDMEM, RER, cu_A, cu_B};

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [2:0] es, input logic [9:0] ev, input logic ei);
        chk({tag, ".state"}, {7'd0, state}, {7'd0, es});
        chk({tag, ".strobes"}, vec, ev);
        chk({tag, ".illegal"}, {9'd0, illegal}, {9'd0, ei});
        chk({tag, ".retired"}, {2'd0, retired}, {2'd0, ret});
    endtask

    task automatic cyc(input string tag, input logic [2:0] es, input logic [9:0] ev, input logic ei);
        @(negedge clk);
        look(tag, es, ev, ei);
    endtask

    task automatic ins(input string tag, input logic [3:0] op, input logic [9:0] e1,
                       input logic [9:0] e2, input bit two, input logic ill);
        ir_op = op;
        cyc({tag, ".fetch"}, FETCH, 10'h040, 1'b0);
        cyc({tag, ".incpc"}, INCPC, 10'h180, 1'b0);
        cyc({tag, ".exec1"}, EXEC1, e1, ill);
        if (two) cyc({tag, ".exec2"}, EXEC2, e2, 1'b0);
        ret = ret + 8'd1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        look("reset", IDLE, 10'h000, 1'b0);
        @(posedge clk);
        #1 reset_full = 1'b1;
        ir_op = 4'h1;
        cyc("idle", IDLE, 10'h000, 1'b0);
        ins("lda", 4'h1, 10'h00C, 10'h000, 1'b0, 1'b0);
        ins("ldb", 4'h2, 10'h003, 10'h000, 1'b0, 1'b0);
        ins("add", 4'h3, 10'h010, 10'h000, 1'b0, 1'b0);
        ins("str", 4'h4, 10'h020, 10'h000, 1'b0, 1'b0);
        ins("clr", 4'h6, 10'h00A, 10'h000, 1'b0, 1'b0);
        ins("adda", 4'h5, 10'h010, 10'h004, 1'b1, 1'b0);
        ins("ill", 4'hA, 10'h000, 10'h000, 1'b0, 1'b1);
        ins("nop", 4'h0, 10'h000, 10'h000, 1'b0, 1'b0);
        ins("ill7", 4'h7, 10'h000, 10'h000, 1'b0, 1'b1);
        ins("illE", 4'hE, 10'h000, 10'h000, 1'b0, 1'b1);
        for (int i = 0; i < 246; i++) ins("nopw", 4'h0, 10'h000, 10'h000, 1'b0, 1'b0);
        ir_op = 4'h5;
        cyc("wrap.fetch", FETCH, 10'h040, 1'b0);
        chk("wrap.zero", {2'd0, retired}, 10'd0);
        cyc("mid.incpc", INCPC, 10'h180, 1'b0);
        cyc("mid.exec1", EXEC1, 10'h010, 1'b0);
        @(posedge clk);
        #1 look("mid.exec2", EXEC2, 10'h004, 1'b0);
        reset_full = 1'b0;
        ret = 8'd0;
        #1 look("mid.reset", IDLE, 10'h000, 1'b0);
        @(posedge clk);
        #1 look("mid.hold", IDLE, 10'h000, 1'b0);
        reset_full = 1'b1;
        ir_op = 4'hF;
        cyc("rel.idle", IDLE, 10'h000, 1'b0);
        cyc("hlt.fetch", FETCH, 10'h040, 1'b0);
        cyc("hlt.incpc", INCPC, 10'h180, 1'b0);
        for (int i = 0; i < 21; i++) begin
            cyc("halt", HALT, 10'h200, 1'b0);
            ir_op = 4'(i);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
